// File: rtl/alu_wb_collector.sv
// Purpose: buffers lane ALU results in a show-ahead FIFO, drains them to the VRF write port, counts one instruction's writes.
// Latency: 1 cycle from ALU push to vrf_wen_o; done_o 1 cycle after the last counted VRF handshake.
// Backpressure: vrf_ready_i stalls the drain; alu_stall_o rises ALU_LAT entries early; a push into a full FIFO without a pop is dropped (ovf_o).
module alu_wb_collector #(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 4,
    parameter int VRF_AW  = 9,
    parameter int VL_W    = 11
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start_i,
    input  logic [VL_W-1:0]          vl_i,
    input  logic                     flush_i,
    input  logic                     alu_vld_i,
    input  logic [31:0]              alu_result_i,
    input  logic [VRF_AW-1:0]        alu_waddr_i,
    input  logic [3:0]               alu_bwe_i,
    output logic                     alu_stall_o,
    output logic                     vrf_wen_o,
    output logic [VRF_AW-1:0]        vrf_waddr_o,
    output logic [31:0]              vrf_wdata_o,
    output logic [3:0]               vrf_bwe_o,
    input  logic                     vrf_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - ALU_LAT);

    typedef struct packed {
        logic [VRF_AW-1:0] waddr;
        logic [31:0]       wdata;
        logic [3:0]        bwe;
    } wb_entry_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    wb_entry_t          mem [DEPTH];
    wb_entry_t          head;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [VL_W-1:0]    remaining;
    state_t             state;
    logic               push;
    logic               pop;
    logic               full;
    logic               push_ok;

    assign push    = alu_vld_i;
    assign pop     = vrf_wen_o & vrf_ready_i;
    assign full    = (count == FULL_CNT);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push_ok = push & (~full | pop);

    assign head        = mem[rd_ptr];
    assign vrf_wen_o   = (count != '0);
    // Data outputs are gated so an empty FIFO (and reset) presents zeros, not stale RAM.
    assign vrf_waddr_o = vrf_wen_o ? head.waddr : '0;
    assign vrf_wdata_o = vrf_wen_o ? head.wdata : '0;
    assign vrf_bwe_o   = vrf_wen_o ? head.bwe   : '0;
    assign count_o     = count;
    assign alu_stall_o = (count >= STALL_CNT);
    assign busy_o      = (state == ACTIVE);

    // Entry storage: written at the tail on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem[wr_ptr] <= '{waddr: alu_waddr_i, wdata: alu_result_i, bwe: alu_bwe_i};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag; flush wins over push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop) begin
                count <= count - CW'(1);
            end
            if (push && !push_ok) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // Instruction tracker: counts accepted VRF writes down from vl and pulses done after the last.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
            done_o    <= 1'b0;
        end else if (flush_i) begin
            state     <= IDLE;
            remaining <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (vl_i != '0) begin
                            state     <= ACTIVE;
                            remaining <= vl_i;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (pop) begin
                        remaining <= remaining - VL_W'(1);
                        if (remaining == VL_W'(1)) begin
                            state  <= IDLE;
                            done_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
